// File: rtl/change_dispenser.sv
// Coin-return payout engine: pays an amount back as greedy dime-first
// dispense requests, each a req/ack handshake guarded by a watchdog.
module change_dispenser #(
  parameter int unsigned AMT_W   = 6,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             dime_empty,
  input  logic             nickel_empty,
  input  logic             ack,
  output logic             D,
  output logic             N,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remain
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [AMT_W-1:0] DIME_C   = AMT_W'(10);
  localparam logic [AMT_W-1:0] NICKEL_C = AMT_W'(5);
  localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_REQ,
    S_REL,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic             d_q, d_d;
  logic             n_q, n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    n_d      = n_q;
    err_d    = err_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d = amount;
          err_d    = 1'b0;
          state_d  = S_SEL;
        end
      end
      S_SEL: begin
        cnt_d = '0;
        if (remain_q == '0) begin
          state_d = S_FIN;
        end else if (remain_q >= DIME_C && !dime_empty) begin
          d_d     = 1'b1;
          state_d = S_REQ;
        end else if (remain_q >= NICKEL_C && !nickel_empty) begin
          n_d     = 1'b1;
          state_d = S_REQ;
        end else begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_REQ: begin
        // A coin is only requested when remain covers it, so no underflow
        if (ack) begin
          d_d      = 1'b0;
          n_d      = 1'b0;
          remain_d = remain_q - (d_q ? DIME_C : NICKEL_C);
          state_d  = S_REL;
        end else if (cnt_q + ONE_C == TMO_C) begin
          d_d     = 1'b0;
          n_d     = 1'b0;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_REL: begin
        if (!ack) begin
          state_d = S_SEL;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        d_d     = 1'b0;
        n_d     = 1'b0;
      end
    endcase

    // FIN always lasts one cycle, so entering it yields a single done pulse
    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      d_q      <= 1'b0;
      n_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      n_q      <= n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  assign D      = d_q;
  assign N      = n_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign remain = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a behavioural coin ejector
// stepped on the falling edge alongside output sampling.
module tb_change_dispenser;

  localparam int unsigned AMT_W   = 6;
  localparam int unsigned TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             dime_empty;
  logic             nickel_empty;
  logic             ack;
  logic             D;
  logic             N;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remain;

  int checks = 0;
  int errors = 0;

  // Ejector model and per-run statistics
  bit ej_en;
  int ej_lat;
  int ej_hold;
  int req_cnt;
  int hold_cnt;
  bit ack_fell;
  bit prev_d;
  bit prev_n;
  bit both_seen;
  int n_dimes;
  int n_nickels;
  int d_high;
  int rem_log[$];

  change_dispenser #(
    .AMT_W  (AMT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .amount      (amount),
    .dime_empty  (dime_empty),
    .nickel_empty(nickel_empty),
    .ack         (ack),
    .D           (D),
    .N           (N),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .remain      (remain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_dimes   = 0;
    n_nickels = 0;
    d_high    = 0;
    both_seen = 0;
    rem_log.delete();
  endtask

  // One clock: sample at the falling edge, then update the ejector
  task automatic step();
    @(negedge clk);
    ack_fell = 0;
    if (D && N) both_seen = 1;
    if (D && !prev_d) n_dimes++;
    if (N && !prev_n) n_nickels++;
    if ((prev_d && !D) || (prev_n && !N)) rem_log.push_back(int'(remain));
    if (D) d_high++;
    prev_d = D;
    prev_n = N;
    if (D || N) begin
      req_cnt++;
      if (ej_en && req_cnt >= ej_lat) ack = 1'b1;
    end else begin
      req_cnt = 0;
      if (ack) begin
        if (hold_cnt >= ej_hold) begin
          ack      = 1'b0;
          hold_cnt = 0;
          ack_fell = 1;
        end else begin
          hold_cnt++;
        end
      end
    end
  endtask

  // Pulse start, optionally poke a second start mid-run, wait for done
  task automatic run(input string tag, input int amt, input int poke_at, output int cyc);
    clear_stats();
    start  = 1'b1;
    amount = AMT_W'(amt);
    step();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 300) begin
      if (cyc == poke_at) begin
        start  = 1'b1;
        amount = AMT_W'(40);
      end
      step();
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    int guard;
    bit req_in_hold;

    rst = 1'b0; start = 1'b0; amount = '0;
    dime_empty = 1'b0; nickel_empty = 1'b0; ack = 1'b0;
    ej_en = 1; ej_lat = 2; ej_hold = 0;
    req_cnt = 0; hold_cnt = 0; prev_d = 0; prev_n = 0;
    clear_stats();

    step();
    step();
    check("reset_outs", {26'd0, D, N, busy, done, err, 1'b0}, 32'd0);
    check("reset_remain", 32'(remain), 32'd0);
    rst = 1'b1;
    step();

    // 15 cents: dime then nickel, 10 cycles start to done
    run("t15", 15, 0, cyc);
    check("t15_cycles", 32'(cyc), 32'd10);
    check("t15_busy_at_done", 32'(busy), 32'd1);
    check("t15_err", 32'(err), 32'd0);
    check("t15_remain", 32'(remain), 32'd0);
    check("t15_dimes", 32'(n_dimes), 32'd1);
    check("t15_nickels", 32'(n_nickels), 32'd1);
    check("t15_nlog", 32'(rem_log.size()), 32'd2);
    if (rem_log.size() == 2) begin
      check("t15_rem0", 32'(rem_log[0]), 32'd5);
      check("t15_rem1", 32'(rem_log[1]), 32'd0);
    end
    check("t15_exclusive", 32'(both_seen), 32'd0);
    step();
    check("t15_done_pulse", {30'd0, done, busy}, 32'd0);

    // 20 cents with dimes empty: four nickels
    dime_empty = 1'b1;
    run("t20", 20, 0, cyc);
    check("t20_dimes", 32'(n_dimes), 32'd0);
    check("t20_nickels", 32'(n_nickels), 32'd4);
    check("t20_err", 32'(err), 32'd0);
    check("t20_nlog", 32'(rem_log.size()), 32'd4);
    if (rem_log.size() == 4) begin
      check("t20_rem0", 32'(rem_log[0]), 32'd15);
      check("t20_rem1", 32'(rem_log[1]), 32'd10);
      check("t20_rem2", 32'(rem_log[2]), 32'd5);
      check("t20_rem3", 32'(rem_log[3]), 32'd0);
    end
    dime_empty = 1'b0;
    step();

    // 7 cents: one nickel, then error with 2 owed; err holds in IDLE
    run("t7", 7, 0, cyc);
    check("t7_nickels", 32'(n_nickels), 32'd1);
    check("t7_dimes", 32'(n_dimes), 32'd0);
    check("t7_err", 32'(err), 32'd1);
    check("t7_remain", 32'(remain), 32'd2);
    step();
    check("t7_err_hold", {30'd0, err, busy}, 32'd2);

    // Zero amount: done two cycles after start, no request, err cleared
    run("t0", 0, 0, cyc);
    check("t0_cycles", 32'(cyc), 32'd2);
    check("t0_reqs", 32'(n_dimes + n_nickels), 32'd0);
    check("t0_err", 32'(err), 32'd0);
    step();

    // Both tubes empty
    dime_empty = 1'b1; nickel_empty = 1'b1;
    run("tempty", 10, 0, cyc);
    check("tempty_cycles", 32'(cyc), 32'd2);
    check("tempty_err", 32'(err), 32'd1);
    check("tempty_remain", 32'(remain), 32'd10);
    dime_empty = 1'b0; nickel_empty = 1'b0;
    step();

    // Watchdog: no ack, dime held exactly TIMEOUT cycles
    ej_en = 0;
    run("ttmo", 10, 0, cyc);
    check("ttmo_d_high", 32'(d_high), 32'(TIMEOUT));
    check("ttmo_cycles", 32'(cyc), 32'(TIMEOUT + 2));
    check("ttmo_err", 32'(err), 32'd1);
    check("ttmo_remain", 32'(remain), 32'd10);
    check("ttmo_d_low", 32'(D), 32'd0);
    step();

    // Ack in the final watchdog cycle credits the coin
    ej_en = 1; ej_lat = TIMEOUT;
    run("tlast", 10, 0, cyc);
    check("tlast_err", 32'(err), 32'd0);
    check("tlast_remain", 32'(remain), 32'd0);
    check("tlast_dimes", 32'(n_dimes), 32'd1);
    ej_lat = 2;
    step();

    // Start during payout is ignored
    run("tpoke", 20, 3, cyc);
    check("tpoke_dimes", 32'(n_dimes), 32'd2);
    check("tpoke_nickels", 32'(n_nickels), 32'd0);
    check("tpoke_remain", 32'(remain), 32'd0);
    check("tpoke_err", 32'(err), 32'd0);
    step();

    // Reset while a dime request is outstanding
    ej_en = 0;
    clear_stats();
    start = 1'b1; amount = AMT_W'(30);
    step();
    start = 1'b0;
    guard = 0;
    while (!D && guard < 20) begin
      step();
      guard++;
    end
    check("trst_d_seen", 32'(D), 32'd1);
    rst = 1'b0;
    step();
    check("trst_outs", {26'd0, D, N, busy, done, err, 1'b0}, 32'd0);
    check("trst_remain", 32'(remain), 32'd0);
    rst = 1'b1; ej_en = 1;
    step();
    run("tfresh", 15, 0, cyc);
    check("tfresh_cycles", 32'(cyc), 32'd10);
    check("tfresh_remain", 32'(remain), 32'd0);
    check("tfresh_err", 32'(err), 32'd0);
    step();

    // Ack held high after the first dime delays the next request
    ej_lat = 1; ej_hold = 5;
    clear_stats();
    start = 1'b1; amount = AMT_W'(20);
    step();
    start = 1'b0;
    guard = 0;
    while (!(prev_d && !D) && rem_log.size() == 0 && guard < 40) begin
      step();
      guard++;
    end
    check("thold_first_drop", 32'(rem_log.size()), 32'd1);
    req_in_hold = 0;
    guard = 0;
    while (!ack_fell && guard < 40) begin
      step();
      if (D || N) req_in_hold = 1;
      guard++;
    end
    check("thold_ack_fell", 32'(ack_fell), 32'd1);
    check("thold_no_req", 32'(req_in_hold), 32'd0);
    step();
    check("thold_gap", 32'(D), 32'd0);
    step();
    check("thold_next_req", 32'(D), 32'd1);
    guard = 0;
    while (!done && guard < 60) begin
      step();
      guard++;
    end
    check("thold_done", 32'(done), 32'd1);
    check("thold_remain", 32'(remain), 32'd0);
    check("thold_dimes", 32'(n_dimes), 32'd2);
    ej_hold = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
